// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//
// Shares one blocking, fixed-latency integer divider among several requesters.
// One unsigned divide is accepted at a time. Requesters are chosen round-robin
// from a priority pointer. The block strobes the divider once, counts out its
// latency and hands quotient/remainder back to the winner with a one-hot
// response strobe. Divide-by-zero never reaches the divider: it is answered
// directly with an all-ones quotient and remainder = dividend. After every
// reset the block waits a full divider latency before granting, so a divide
// left running across the reset cannot corrupt the next result.
//
// Parameters
//   WIDTH        operand / result width (unsigned)
//   REQUESTERS   number of requesters (2..8)
//   DIV_LATENCY  cycles from divider start strobe to stable results (>= 2)
//
// Ports
//   clk_in              system clock, rising edge
//   rst_n_in            asynchronous active-low reset
//   req_valid_in        per-requester request
//   req_dividend_in     packed dividends, requester i at [i*WIDTH +: WIDTH]
//   req_divisor_in      packed divisors, same packing
//   req_ready_out       one-hot accept strobe (taken when valid & ready)
//   resp_valid_out      one-hot single-cycle result strobe
//   resp_quotient_out   quotient, meaningful with resp_valid_out
//   resp_remainder_out  remainder, meaningful with resp_valid_out
//   resp_div_zero_out   high with resp_valid_out when the divisor was zero
//   div_dividend_out    registered dividend to the divider
//   div_divisor_out     registered divisor to the divider
//   div_valid_out       single-cycle start strobe to the divider
//   div_quotient_in     quotient from the divider
//   div_remainder_in    remainder from the divider
// -----------------------------------------------------------------------------
module div_arbiter #(
    parameter int WIDTH       = 64,
    parameter int REQUESTERS  = 4,
    parameter int DIV_LATENCY = 66
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [REQUESTERS-1:0]         req_valid_in,
    input  logic [REQUESTERS*WIDTH-1:0]   req_dividend_in,
    input  logic [REQUESTERS*WIDTH-1:0]   req_divisor_in,
    output logic [REQUESTERS-1:0]         req_ready_out,
    output logic [REQUESTERS-1:0]         resp_valid_out,
    output logic [WIDTH-1:0]              resp_quotient_out,
    output logic [WIDTH-1:0]              resp_remainder_out,
    output logic                          resp_div_zero_out,
    output logic [WIDTH-1:0]              div_dividend_out,
    output logic [WIDTH-1:0]              div_divisor_out,
    output logic                          div_valid_out,
    input  logic [WIDTH-1:0]              div_quotient_in,
    input  logic [WIDTH-1:0]              div_remainder_in
);

    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int CNT_W = $clog2(DIV_LATENCY + 1);

    localparam logic [CNT_W-1:0] FLUSH_COUNT = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] WAIT_COUNT  = CNT_W'(DIV_LATENCY - 1);
    localparam logic [IDX_W:0]   REQ_COUNT   = (IDX_W + 1)'(REQUESTERS);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(REQUESTERS - 1);

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               div_zero_q, div_zero_d;

    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     arb_sum;
    logic [IDX_W-1:0]   arb_cand;
    logic [WIDTH-1:0]   sel_dividend;
    logic [WIDTH-1:0]   sel_divisor;

    // Round-robin search: walk the requesters starting at the pointer and
    // wrap once past the last index; the first valid one wins. The sum is one
    // bit wider than an index so the wrap works for non-power-of-two counts.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        arb_sum     = '0;
        arb_cand    = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            arb_sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (arb_sum >= REQ_COUNT) begin
                arb_sum = arb_sum - REQ_COUNT;
            end
            arb_cand = arb_sum[IDX_W-1:0];
            if (!grant_valid && req_valid_in[arb_cand]) begin
                grant_valid = 1'b1;
                grant_idx   = arb_cand;
            end
        end
    end

    // Operands of the current arbitration winner.
    always_comb begin
        sel_dividend = req_dividend_in[int'(grant_idx)*WIDTH +: WIDTH];
        sel_divisor  = req_divisor_in[int'(grant_idx)*WIDTH +: WIDTH];
    end

    // Sequencer next-state and strobe logic. The shared counter drains the
    // divider after reset in FLUSH and counts the divider latency in WAIT.
    // Zero divisors skip the divider and go straight to RESPOND.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ptr_d          = ptr_q;
        winner_d       = winner_q;
        dividend_d     = dividend_q;
        divisor_d      = divisor_q;
        quot_d         = quot_q;
        rem_d          = rem_q;
        div_zero_d     = div_zero_q;
        req_ready_out  = '0;
        resp_valid_out = '0;
        div_valid_out  = 1'b0;

        case (state_q)
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            IDLE: begin
                if (grant_valid) begin
                    req_ready_out[grant_idx] = 1'b1;
                    winner_d   = grant_idx;
                    ptr_d      = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                    dividend_d = sel_dividend;
                    divisor_d  = sel_divisor;
                    if (sel_divisor == '0) begin
                        quot_d     = '1;
                        rem_d      = sel_dividend;
                        div_zero_d = 1'b1;
                        state_d    = RESPOND;
                    end else begin
                        div_zero_d = 1'b0;
                        state_d    = ISSUE;
                    end
                end
            end

            ISSUE: begin
                div_valid_out = 1'b1;
                cnt_d         = WAIT_COUNT;
                state_d       = WAIT;
            end

            WAIT: begin
                if (cnt_q == '0) begin
                    quot_d  = div_quotient_in;
                    rem_d   = div_remainder_in;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            RESPOND: begin
                resp_valid_out[winner_q] = 1'b1;
                state_d                  = IDLE;
            end

            default: begin
                state_d = FLUSH;
                cnt_d   = FLUSH_COUNT;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any operation in progress
    // and restarts the drain period with the counter at the full latency.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= FLUSH;
            cnt_q      <= FLUSH_COUNT;
            ptr_q      <= '0;
            winner_q   <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Every data output comes straight from a register, so nothing from the
    // divider reaches an output combinationally. The zero flag is qualified
    // by the response state so it only shows alongside a response strobe.
    always_comb begin
        div_dividend_out   = dividend_q;
        div_divisor_out    = divisor_q;
        resp_quotient_out  = quot_q;
        resp_remainder_out = rem_q;
        resp_div_zero_out  = (state_q == RESPOND) && div_zero_q;
    end

    // Structural invariants of the handshake strobes.
    a_ready_onehot : assert property (@(posedge clk_in) disable iff (!rst_n_in)
        $onehot0(req_ready_out));
    a_resp_onehot : assert property (@(posedge clk_in) disable iff (!rst_n_in)
        $onehot0(resp_valid_out));
    a_issue_exclusive : assert property (@(posedge clk_in) disable iff (!rst_n_in)
        div_valid_out |-> (req_ready_out == '0 && resp_valid_out == '0));

endmodule

// File: tb/tb_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_arbiter
//
// Self-checking bench for div_arbiter. A transaction-level model tracks the
// round-robin pointer and the cycle at which each grant, divider strobe and
// response must appear, and one compare process checks the DUT against it on
// every cycle. A behavioural divider answers the DUT with a correct result
// only during the single cycle the DUT is supposed to sample it. Directed
// scenarios add hand-computed literal expectations on top of the model.
// -----------------------------------------------------------------------------
module tb_div_arbiter;

    localparam int W = 64;
    localparam int N = 4;
    localparam int L = 66;

    localparam logic [W-1:0] GARBAGE_XOR = 64'h5A5A_0F0F_1234_8765;
    localparam logic [W-1:0] GARBAGE_Z   = 64'hDEAD_BEEF_0BAD_F00D;

    logic               clk_in;
    logic               rst_n_in;
    logic [N-1:0]       req_valid_in;
    logic [N*W-1:0]     req_dividend_in;
    logic [N*W-1:0]     req_divisor_in;
    logic [N-1:0]       req_ready_out;
    logic [N-1:0]       resp_valid_out;
    logic [W-1:0]       resp_quotient_out;
    logic [W-1:0]       resp_remainder_out;
    logic               resp_div_zero_out;
    logic [W-1:0]       div_dividend_out;
    logic [W-1:0]       div_divisor_out;
    logic               div_valid_out;
    logic [W-1:0]       div_quotient_in;
    logic [W-1:0]       div_remainder_in;

    div_arbiter #(
        .WIDTH       (W),
        .REQUESTERS  (N),
        .DIV_LATENCY (L)
    ) dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .req_valid_in       (req_valid_in),
        .req_dividend_in    (req_dividend_in),
        .req_divisor_in     (req_divisor_in),
        .req_ready_out      (req_ready_out),
        .resp_valid_out     (resp_valid_out),
        .resp_quotient_out  (resp_quotient_out),
        .resp_remainder_out (resp_remainder_out),
        .resp_div_zero_out  (resp_div_zero_out),
        .div_dividend_out   (div_dividend_out),
        .div_divisor_out    (div_divisor_out),
        .div_valid_out      (div_valid_out),
        .div_quotient_in    (div_quotient_in),
        .div_remainder_in   (div_remainder_in)
    );

    // Free-running clock, period 10.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int errors;
    int checks;

    // One comparison: counts it, and reports a FAIL line on a mismatch.
    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Behavioural divider: the true result is presented only in the one cycle
    // that ends DIV_LATENCY edges after the start strobe was sampled; any other
    // cycle carries a deliberately wrong value.
    int           divEdge;
    int           divStart;
    logic [W-1:0] divA;
    logic [W-1:0] divB;
    logic         divSaw;

    initial begin
        divEdge          = 0;
        divStart         = -1000;
        divA             = '0;
        divB             = '0;
        divSaw           = 1'b0;
        div_quotient_in  = GARBAGE_Z;
        div_remainder_in = GARBAGE_Z;
        forever begin
            @(negedge clk_in);
            divSaw = (div_valid_out === 1'b1);
            if (divSaw) begin
                divA = div_dividend_out;
                divB = div_divisor_out;
            end
            @(posedge clk_in);
            #1;
            divEdge++;
            if (divSaw) divStart = divEdge;
            if (divB == '0) begin
                div_quotient_in  = GARBAGE_Z;
                div_remainder_in = GARBAGE_Z;
            end else if (divEdge == divStart + L - 1) begin
                div_quotient_in  = divA / divB;
                div_remainder_in = divA % divB;
            end else begin
                div_quotient_in  = (divA / divB) ^ GARBAGE_XOR;
                div_remainder_in = (divA % divB) ^ GARBAGE_XOR;
            end
        end
    end

    // Reference model and the per-cycle compare. The model works in cycle
    // numbers since reset release: a grant in cycle c means a divider strobe
    // in c+1, a response in c+2+L and the next possible grant in c+3+L; a zero
    // divisor answers in c+1. After release no grant before cycle L+1.
    int           mc;
    int           mPtr;
    int           mNextFree;
    int           mDivAt;
    int           mRespAt;
    int           mRespIdx;
    logic [W-1:0] mDa;
    logic [W-1:0] mDb;
    logic [W-1:0] mQ;
    logic [W-1:0] mR;
    logic         mDz;

    initial begin : model
        logic [N-1:0] expReady;
        logic [N-1:0] expResp;
        int           win;
        int           cand;
        mc = 0; mPtr = 0; mNextFree = L + 1; mDivAt = -1; mRespAt = -1;
        mRespIdx = 0; mDa = '0; mDb = '0; mQ = '0; mR = '0; mDz = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                checkOutput("reset ready", W'(req_ready_out), '0);
                checkOutput("reset resp_valid", W'(resp_valid_out), '0);
                checkOutput("reset div_valid", W'(div_valid_out), '0);
                checkOutput("reset div_zero", W'(resp_div_zero_out), '0);
                checkOutput("reset quotient", resp_quotient_out, '0);
                checkOutput("reset div_dividend", div_dividend_out, '0);
                mc = 0; mPtr = 0; mNextFree = L + 1; mDivAt = -1; mRespAt = -1;
            end else begin
                expReady = '0;
                win      = -1;
                if (mc >= mNextFree) begin
                    for (int k = 0; k < N; k++) begin
                        cand = (mPtr + k) % N;
                        if (win < 0 && ((req_valid_in >> cand) & N'(1)) != '0) win = cand;
                    end
                end
                if (win >= 0) expReady = N'(1) << win;
                expResp = (mc == mRespAt) ? (N'(1) << mRespIdx) : '0;

                checkOutput("ready", W'(req_ready_out), W'(expReady));
                checkOutput("div_valid", W'(div_valid_out), W'(mc == mDivAt));
                if (mc == mDivAt) begin
                    checkOutput("div_dividend", div_dividend_out, mDa);
                    checkOutput("div_divisor", div_divisor_out, mDb);
                end
                checkOutput("resp_valid", W'(resp_valid_out), W'(expResp));
                checkOutput("resp_div_zero", W'(resp_div_zero_out),
                            W'((mc == mRespAt) && mDz));
                if (mc == mRespAt) begin
                    checkOutput("resp_quotient", resp_quotient_out, mQ);
                    checkOutput("resp_remainder", resp_remainder_out, mR);
                end

                if (win >= 0) begin
                    mRespIdx = win;
                    mPtr     = (win + 1) % N;
                    mDa      = req_dividend_in[win*W +: W];
                    mDb      = req_divisor_in[win*W +: W];
                    if (mDb == '0) begin
                        mQ      = '1;
                        mR      = mDa;
                        mDz     = 1'b1;
                        mRespAt = mc + 1;
                    end else begin
                        mQ      = mDa / mDb;
                        mR      = mDa % mDb;
                        mDz     = 1'b0;
                        mDivAt  = mc + 1;
                        mRespAt = mc + 2 + L;
                    end
                    mNextFree = mRespAt + 1;
                end
                mc++;
            end
        end
    end

    // Observation log filled by the stimulus stepper.
    typedef struct {
        int           t;
        logic [N-1:0] idx;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } resp_t;

    resp_t        rlog[$];
    int           tick;
    int           firstReadyTick;
    int           lastAccept;
    int           lastDivTick;
    int           divCount;
    logic [N-1:0] accepted;
    logic [N-1:0] readySeen;
    logic [N-1:0] autoDrop;

    task automatic applyStimulus(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend_in[i*W +: W] = a;
        req_divisor_in[i*W +: W]  = b;
        req_valid_in[i]           = 1'b1;
    endtask

    // Advance one cycle: observe at the falling edge, then drop the valid of
    // any accepted requester (unless it is meant to keep requesting).
    task automatic step();
        resp_t e;
        accepted = '0;
        @(negedge clk_in);
        if (rst_n_in) begin
            accepted  = req_valid_in & req_ready_out;
            readySeen = readySeen | req_ready_out;
            if (req_ready_out != '0 && firstReadyTick < 0) firstReadyTick = tick;
            if (accepted != '0) lastAccept = tick;
            if (div_valid_out) begin
                divCount++;
                lastDivTick = tick;
            end
            if (resp_valid_out != '0) begin
                e.t   = tick;
                e.idx = resp_valid_out;
                e.q   = resp_quotient_out;
                e.r   = resp_remainder_out;
                e.dz  = resp_div_zero_out;
                rlog.push_back(e);
            end
        end
        @(posedge clk_in);
        #1;
        req_valid_in = req_valid_in & ~(accepted & autoDrop);
        tick++;
    endtask

    task automatic waitResponses(input int n, input int bound);
        int s;
        s = 0;
        while (rlog.size() < n && s < bound) begin
            step();
            s++;
        end
        checkOutput("response count", W'(rlog.size()), W'(n));
    endtask

    task automatic releaseReset();
        rst_n_in       = 1'b1;
        tick           = 0;
        firstReadyTick = -1;
        readySeen      = '0;
        rlog.delete();
    endtask

    task automatic checkResp(input string name, input int k, input logic [N-1:0] idx,
                             input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        if (rlog.size() > k) begin
            checkOutput({name, " idx"}, W'(rlog[k].idx), W'(idx));
            checkOutput({name, " q"}, rlog[k].q, q);
            checkOutput({name, " r"}, rlog[k].r, r);
            checkOutput({name, " dz"}, W'(rlog[k].dz), W'(dz));
        end
    endtask

    initial begin : stimulus
        int n;
        errors          = 0;
        checks          = 0;
        rst_n_in        = 1'b0;
        req_valid_in    = '0;
        req_dividend_in = '0;
        req_divisor_in  = '0;
        autoDrop        = '1;
        tick            = 0;
        firstReadyTick  = -1;
        lastAccept      = -1;
        lastDivTick     = -1;
        divCount        = 0;
        readySeen       = '0;
        accepted        = '0;

        repeat (3) step();
        checkOutput("por ready", W'(req_ready_out), '0);
        checkOutput("por div_valid", W'(div_valid_out), '0);
        checkOutput("por remainder", resp_remainder_out, '0);

        // All four requesters waiting from reset release: served 0,1,2,3.
        for (int i = 0; i < N; i++) applyStimulus(i, W'(1000 + i), W'(i + 3));
        releaseReset();
        waitResponses(4, 400);
        checkResp("all4 r0", 0, 4'b0001, 333, 1, 1'b0);
        checkResp("all4 r1", 1, 4'b0010, 250, 1, 1'b0);
        checkResp("all4 r2", 2, 4'b0100, 200, 2, 1'b0);
        checkResp("all4 r3", 3, 4'b1000, 167, 1, 1'b0);
        if (rlog.size() >= 4) begin
            for (int k = 0; k < 3; k++)
                checkOutput("all4 spacing", W'(rlog[k+1].t - rlog[k].t), W'(69));
        end
        checkOutput("flush holds off grants", W'(firstReadyTick >= L), W'(1));

        // Single request from requester 2: 100/7.
        rlog.delete();
        applyStimulus(2, 100, 7);
        waitResponses(1, 120);
        checkResp("single", 0, 4'b0100, 14, 2, 1'b0);
        checkOutput("single div strobe", W'(lastDivTick - lastAccept), W'(1));
        if (rlog.size() >= 1)
            checkOutput("single latency", W'(rlog[0].t - lastAccept), W'(68));

        // Divide by zero from requester 1: 55/0, no divider strobe.
        rlog.delete();
        n = divCount;
        applyStimulus(1, 55, 0);
        waitResponses(1, 20);
        checkResp("divzero", 0, 4'b0010, '1, 55, 1'b1);
        if (rlog.size() >= 1)
            checkOutput("divzero latency", W'(rlog[0].t - lastAccept), W'(1));
        checkOutput("divzero no strobe", W'(divCount - n), W'(0));

        // Fairness: requester 0 requests continuously, requester 3 once.
        rlog.delete();
        autoDrop = 4'b1110;
        applyStimulus(0, 20, 6);
        n = 0;
        while (!accepted[0] && n < 20) begin
            step();
            n++;
        end
        checkOutput("fair first grant", W'(accepted), W'(4'b0001));
        applyStimulus(3, 81, 9);
        waitResponses(3, 300);
        req_valid_in[0] = 1'b0;
        autoDrop        = '1;
        checkResp("fair g1", 0, 4'b0001, 3, 2, 1'b0);
        checkResp("fair g2", 1, 4'b1000, 9, 0, 1'b0);
        checkResp("fair g3", 2, 4'b0001, 3, 2, 1'b0);
        repeat (3) step();

        // Reset during WAIT aborts requester 0; a dropped request in FLUSH
        // is never served while the re-issued one completes.
        rlog.delete();
        applyStimulus(0, 500, 7);
        n = 0;
        while (!accepted[0] && n < 20) begin
            step();
            n++;
        end
        repeat (10) step();
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("async ready", W'(req_ready_out), '0);
        checkOutput("async div_valid", W'(div_valid_out), '0);
        checkOutput("async div_dividend", div_dividend_out, '0);
        checkOutput("async div_divisor", div_divisor_out, '0);
        checkOutput("async resp_valid", W'(resp_valid_out), '0);
        repeat (3) step();
        applyStimulus(0, 500, 7);
        applyStimulus(1, 77, 5);
        releaseReset();
        repeat (20) step();
        req_valid_in[1] = 1'b0;
        waitResponses(1, 200);
        checkResp("reissue", 0, 4'b0001, 71, 3, 1'b0);
        checkOutput("reissue after flush", W'(firstReadyTick >= L), W'(1));
        repeat (80) step();
        checkOutput("dropped never ready", W'(readySeen[1]), W'(0));
        checkOutput("no extra responses", W'(rlog.size()), W'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule
